// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - five-stage multi-cycle instruction sequencer with run/step control
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic        step_mode,
    input  logic        step,
    input  logic        IF_over,
    input  logic        ID_over,
    input  logic        EXE_over,
    input  logic        MEM_over,
    input  logic        WB_over,
    output logic        IF_valid,
    output logic        ID_valid,
    output logic        EXE_valid,
    output logic        MEM_valid,
    output logic        WB_valid,
    output logic        IF_ID_en,
    output logic        ID_EXE_en,
    output logic        EXE_MEM_en,
    output logic        MEM_WB_en,
    output logic        next_fetch,
    output logic [2:0]  cur_stage,
    output logic        halted,
    output logic [31:0] inst_retired,
    output logic [31:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EXE  = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   armed;
    logic   launch;
    logic   wb_done;

    // armed holds off the first launch until the second edge after reset release
    assign launch  = armed & (step_mode ? step : run);
    assign wb_done = (state == S_WB) & WB_over;

    assign IF_ID_en   = resetn & (state == S_IF)  & IF_over;
    assign ID_EXE_en  = resetn & (state == S_ID)  & ID_over;
    assign EXE_MEM_en = resetn & (state == S_EXE) & EXE_over;
    assign MEM_WB_en  = resetn & (state == S_MEM) & MEM_over;
    assign next_fetch = resetn & wb_done;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (launch)   state_nxt = S_IF;
            S_IF:    if (IF_over)  state_nxt = S_ID;
            S_ID:    if (ID_over)  state_nxt = S_EXE;
            S_EXE:   if (EXE_over) state_nxt = S_MEM;
            S_MEM:   if (MEM_over) state_nxt = S_WB;
            S_WB:    if (WB_over)  state_nxt = (run & ~step_mode) ? S_IF : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            armed        <= 1'b0;
            IF_valid     <= 1'b0;
            ID_valid     <= 1'b0;
            EXE_valid    <= 1'b0;
            MEM_valid    <= 1'b0;
            WB_valid     <= 1'b0;
            halted       <= 1'b1;
            cur_stage    <= 3'd0;
            inst_retired <= 32'd0;
            cycle_cnt    <= 32'd0;
        end else begin
            armed     <= 1'b1;
            state     <= state_nxt;
            IF_valid  <= (state_nxt == S_IF);
            ID_valid  <= (state_nxt == S_ID);
            EXE_valid <= (state_nxt == S_EXE);
            MEM_valid <= (state_nxt == S_MEM);
            WB_valid  <= (state_nxt == S_WB);
            halted    <= (state_nxt == S_IDLE);
            cur_stage <= state_nxt;
            if (state != S_IDLE) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (wb_done) begin
                inst_retired <= inst_retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed self-checking bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        run, step_mode, step;
    logic        IF_over, ID_over, EXE_over, MEM_over, WB_over;
    logic        IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
    logic        IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en, next_fetch;
    logic [2:0]  cur_stage;
    logic        halted;
    logic [31:0] inst_retired, cycle_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int n_cyc, n_nf, onehot_bad, exe_en_at, timed_out;
    int v_if, v_id, v_exe, v_mem, v_wb;
    int e_ifid, e_idexe, e_exemem, e_memwb;

    multi_cycle_ctrl dut (
        .clk(clk), .resetn(resetn), .run(run), .step_mode(step_mode), .step(step),
        .IF_over(IF_over), .ID_over(ID_over), .EXE_over(EXE_over),
        .MEM_over(MEM_over), .WB_over(WB_over),
        .IF_valid(IF_valid), .ID_valid(ID_valid), .EXE_valid(EXE_valid),
        .MEM_valid(MEM_valid), .WB_valid(WB_valid),
        .IF_ID_en(IF_ID_en), .ID_EXE_en(ID_EXE_en), .EXE_MEM_en(EXE_MEM_en),
        .MEM_WB_en(MEM_WB_en), .next_fetch(next_fetch),
        .cur_stage(cur_stage), .halted(halted),
        .inst_retired(inst_retired), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch on the next edge, then follow the FSM until it is back in IDLE.
    task automatic run_instrs(input int n, input int exe_stall, input bit step_in_exe,
                              input bit drop_in_id);
        int exe_cnt;
        int vsum;
        exe_cnt = 0; n_cyc = 0; n_nf = 0; onehot_bad = 0; exe_en_at = -1;
        v_if = 0; v_id = 0; v_exe = 0; v_mem = 0; v_wb = 0;
        e_ifid = 0; e_idexe = 0; e_exemem = 0; e_memwb = 0;
        tick();
        step = 1'b0;
        while (!halted && n_cyc < 200) begin
            if (EXE_valid) exe_cnt++;
            EXE_over = !(EXE_valid && exe_cnt <= exe_stall);
            step     = step_in_exe && EXE_valid && exe_cnt == 1;
            if (drop_in_id && ID_valid) run = 1'b0;
            if (WB_valid && n_nf == n - 1) run = 1'b0;
            #1;
            vsum = int'(IF_valid) + int'(ID_valid) + int'(EXE_valid) + int'(MEM_valid) + int'(WB_valid);
            if (vsum != 1) onehot_bad++;
            v_if  += int'(IF_valid);
            v_id  += int'(ID_valid);
            v_exe += int'(EXE_valid);
            v_mem += int'(MEM_valid);
            v_wb  += int'(WB_valid);
            e_ifid   += int'(IF_ID_en);
            e_idexe  += int'(ID_EXE_en);
            e_memwb  += int'(MEM_WB_en);
            if (EXE_MEM_en) begin
                e_exemem++;
                exe_en_at = exe_cnt;
            end
            if (next_fetch) n_nf++;
            tick();
            step = 1'b0;
            n_cyc++;
        end
        timed_out = halted ? 0 : 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; run = 1'b0; step_mode = 1'b0; step = 1'b0;
        IF_over = 1'b1; ID_over = 1'b1; EXE_over = 1'b1; MEM_over = 1'b1; WB_over = 1'b1;
        tick();
        tick();
        check("rst_halted", halted, 1);
        check("rst_stage", cur_stage, 0);
        check("rst_valids", {IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid}, 0);
        check("rst_enables", {IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en, next_fetch}, 0);
        check("rst_retired", inst_retired, 0);
        check("rst_cycles", cycle_cnt, 0);

        // free run, three instructions
        resetn = 1'b1; run = 1'b1;
        tick();
        check("first_edge_no_if", halted, 1);
        run_instrs(3, 0, 0, 0);
        check("fr_timeout", timed_out, 0);
        check("fr_cycles_seen", n_cyc, 15);
        check("fr_onehot", onehot_bad, 0);
        check("fr_valid_each", {v_if[7:0], v_id[7:0], v_exe[7:0], v_wb[7:0]}, 32'h03030303);
        check("fr_valid_mem", v_mem, 3);
        check("fr_en_each", {e_ifid[7:0], e_idexe[7:0], e_exemem[7:0], e_memwb[7:0]}, 32'h03030303);
        check("fr_next_fetch", n_nf, 3);
        check("fr_retired", inst_retired, 3);
        check("fr_cycle_cnt", cycle_cnt, 15);
        check("fr_halted", halted, 1);

        // EXE stall of four cycles
        run = 1'b1;
        run_instrs(1, 4, 0, 0);
        check("st_timeout", timed_out, 0);
        check("st_exe_valid", v_exe, 5);
        check("st_exemem_cnt", e_exemem, 1);
        check("st_exemem_last", exe_en_at, 5);
        check("st_cycle_cnt", cycle_cnt, 24);
        check("st_retired", inst_retired, 4);

        // step mode: no launch without a pulse, one instruction per pulse
        run = 1'b1; step_mode = 1'b1;
        tick();
        tick();
        check("sp_wait_halted", halted, 1);
        check("sp_wait_cycles", cycle_cnt, 24);
        step = 1'b1;
        run_instrs(1, 0, 1, 0);
        check("sp_timeout", timed_out, 0);
        check("sp_cycles_seen", n_cyc, 5);
        check("sp_next_fetch", n_nf, 1);
        check("sp_retired", inst_retired, 5);
        tick();
        tick();
        tick();
        check("sp_stays_idle", {29'd0, cur_stage}, 0);
        check("sp_halted", halted, 1);
        check("sp_retired_after", inst_retired, 5);

        // run dropped during ID
        step_mode = 1'b0; run = 1'b1;
        run_instrs(1, 0, 0, 1);
        check("rd_timeout", timed_out, 0);
        check("rd_next_fetch", n_nf, 1);
        check("rd_retired", inst_retired, 6);
        tick();
        tick();
        tick();
        check("rd_no_new_if", halted, 1);
        check("rd_cycle_cnt", cycle_cnt, 34);

        // reset asserted while holding in MEM
        run = 1'b1; MEM_over = 1'b0;
        tick();
        for (int k = 0; k < 10 && !MEM_valid; k++) tick();
        check("mr_in_mem", MEM_valid, 1);
        #1;
        resetn = 1'b0; MEM_over = 1'b1; WB_over = 1'b1;
        #1;
        check("mr_async_valids", {IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid}, 0);
        check("mr_async_halted", halted, 1);
        check("mr_async_stage", {29'd0, cur_stage}, 0);
        check("mr_async_enables", {IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en, next_fetch}, 0);
        check("mr_retired", inst_retired, 0);
        check("mr_cycles", cycle_cnt, 0);
        tick();
        check("mr_held_enables", {MEM_WB_en, next_fetch}, 0);
        resetn = 1'b1; run = 1'b0;
        tick();

        // retired counter wrap
        force dut.inst_retired = 32'hFFFF_FFFF;
        #1;
        release dut.inst_retired;
        #1;
        check("wr_preset", inst_retired, 32'hFFFF_FFFF);
        run = 1'b1;
        run_instrs(1, 0, 0, 0);
        check("wr_timeout", timed_out, 0);
        check("wr_next_fetch", n_nf, 1);
        check("wr_retired", inst_retired, 0);
        check("wr_cycle_cnt", cycle_cnt, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named `clk` and `resetn`.
REQ-002 The block SHALL expose the following ports (name, direction, width, meaning):
- `clk` in 1: clock, rising-edge.
- `resetn` in 1: asynchronous active-low reset.
- `run` in 1: level; 1 = free-running execution.
- `step_mode` in 1: level; 1 = single-instruction stepping.
- `step` in 1: one-cycle pulse; request one instruction in step mode.
- `IF_over`, `ID_over`, `EXE_over`, `MEM_over`, `WB_over` in 1 each: stage-done strobes.
- `IF_valid`, `ID_valid`, `EXE_valid`, `MEM_valid`, `WB_valid` out 1 each: stage enables.
- `IF_ID_en`, `ID_EXE_en`, `EXE_MEM_en`, `MEM_WB_en` out 1 each: inter-stage bus latch enables.
- `next_fetch` out 1: pulse; fetch updates PC.
- `cur_stage` out 3: state code, for display.
- `halted` out 1: 1 when in IDLE.
- `inst_retired` out 32: retired-instruction count.
- `cycle_cnt` out 32: active-cycle count.

Function
REQ-003 The state machine SHALL have exactly six states, encoded IDLE=0, IF=1, ID=2, EXE=3, MEM=4, WB=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-004 Each `X_valid` SHALL be a Moore output, 1 only in state X; at most one `*_valid` SHALL be high in any cycle.
REQ-005 In state X, `X_over`=1 SHALL move the FSM to the next stage (IF->ID->EXE->MEM->WB) on the next edge; while `X_over`=0 the FSM SHALL hold in X.
REQ-006 `X_over` SHALL be ignored whenever the FSM is not in state X.
REQ-007 Latch enables SHALL be combinational, one cycle wide:
- `IF_ID_en` = (state==IF) & `IF_over`.
- `ID_EXE_en` = (state==ID) & `ID_over`.
- `EXE_MEM_en` = (state==EXE) & `EXE_over`.
- `MEM_WB_en` = (state==MEM) & `MEM_over`.
REQ-008 In WB, `WB_over`=1 SHALL assert `next_fetch` combinationally in that cycle and increment `inst_retired` by 1 on the same edge.
REQ-009 On WB completion, the next state SHALL be IF if `run`=1 and `step_mode`=0; otherwise it SHALL be IDLE.
REQ-010 In IDLE, the FSM SHALL go to IF on the next edge if either condition holds:
- `step_mode`=0 and `run`=1;
- `step_mode`=1 and `step`=1.
Otherwise the FSM SHALL stay in IDLE.
REQ-011 `step` pulses received outside IDLE SHALL be discarded and SHALL NOT be queued.
REQ-012 Deasserting `run` mid-instruction SHALL NOT abort it; the current instruction completes through WB and the FSM then enters IDLE.
REQ-013 Each stage SHALL last at least 1 cycle, so minimum latency is 5 cycles per instruction (IF entry to WB exit) plus 1 cycle per IDLE->IF launch.
REQ-014 `cycle_cnt` SHALL increment by 1 on every edge where the pre-edge state is not IDLE.
REQ-015 Both counters SHALL wrap modulo 2^32 (0xFFFFFFFF -> 0) with no flag.
REQ-016 `cur_stage` SHALL equal the state code; `halted` SHALL be 1 exactly when state==IDLE.
REQ-017 `step_mode` and `run` changes SHALL take effect only at the IDLE and WB-exit decision points.

Reset
REQ-018 While `resetn`=0, the block SHALL force the following immediately, without waiting for `clk`: state=IDLE, all `*_valid`=0, `inst_retired`=0, `cycle_cnt`=0, `halted`=1, `cur_stage`=0.
REQ-019 Combinational outputs (latch enables, `next_fetch`) SHALL be 0 while `resetn`=0.
REQ-020 Assertion of `resetn`=0 mid-instruction SHALL abandon the instruction; no latch enable and no `next_fetch` SHALL occur.
REQ-021 After `resetn` rises, the first IF SHALL occur no earlier than the second rising edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Free-run: `run`=1, `step_mode`=0, all `*_over` tied 1 → repeating IF,ID,EXE,MEM,WB with 1 cycle each; after 3 instructions `inst_retired`=3 and `cycle_cnt`=15; each latch enable high exactly once per instruction.
- Stall: `EXE_over` held 0 for 4 cycles → `EXE_valid` high for 5 cycles; `EXE_MEM_en` high only on the final cycle; `cycle_cnt` per instruction = 9.
- Step: `step_mode`=1 with a `step` pulse → exactly one instruction, then `halted`=1 and `inst_retired`+1; a second `step` pulse during EXE → ignored, FSM stays in IDLE afterwards.
- Run drop: `run` 1→0 during ID → instruction completes, `next_fetch` pulses once, FSM in IDLE, no new IF.
- Mid-reset: `resetn` low during MEM → outputs reset asynchronously, no `MEM_WB_en`/`next_fetch`; counters=0.
- Wrap: `inst_retired` forced to 0xFFFFFFFF, then one instruction completes → `inst_retired`=0.
